btb_predictor: RTL and testbench
================================

# btb_predictor

Parametrised branch target buffer with per-entry saturating direction counters, replacing the fixed single-bit BTB inside the IF stage of the RV32I pipeline. It answers a combinational lookup for the fetch PC every cycle and is trained by the branch/jump unit's EX-stage resolution one cycle later. Geometry (entries, tag width, counter width) is set by parameters. Optional statistics counters are compiled in by macro.

## Interface
- `ENTRIES`, default 16: number of entries; power of two, ≥ 2. `IDX_W` = log2(`ENTRIES`).
- `TAG_W`, default 8: tag bits stored per entry. Requires `IDX_W + TAG_W + 2 ≤ 32`.
- `CTR_W`, default 2: direction counter width, ≥ 1.
- `STAT_W`, default 32: width of each statistics counter (only with the macro).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `lookup_en` in 1: fetch advancing this cycle (`pc_en`); used only for statistics.
- `pc_if` in 32: fetch PC.
- `predicted_taken` out 1: predict taken.
- `predicted_target` out 32: stored target; 0 on miss.
- `btb_hit` out 1: valid entry with matching tag.
- `update_btb_ex` in 1: EX resolved a branch or jump this cycle.
- `pc_ex` in 32: PC of the resolving instruction.
- `jump_addr_ex` in 32: resolved target.
- `ex_branch_taken` in 1: resolved direction.
- `modify_pc_ex` in 1: EX redirected fetch (mispredict); used only for statistics.
- `btb_flush` in 1: synchronous invalidate of all entries.
- `stat_clr` in 1: synchronous clear of the statistics counters (macro only).
- `stat_lookups`, `stat_hits`, `stat_mispredicts` out `STAT_W`: statistics counters (macro only).

## Operation
- Index = `pc[IDX_W+1:2]`. Tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`. Direct-mapped.
- Entry state: `valid`, `tag`, `target[31:0]`, `ctr[CTR_W-1:0]`.
- Lookup is purely combinational from `pc_if`:
  - `btb_hit` = valid && tag match.
  - `predicted_taken` = `btb_hit` && `ctr[CTR_W-1]`.
  - `predicted_target` = stored target when hit, else 0.
- Update, when `update_btb_ex`=1:
  - Hit on `pc_ex` index/tag, taken: `ctr` increments, saturating at all-ones; `target` ← `jump_addr_ex`.
  - Hit, not taken: `ctr` decrements, saturating at 0; `target` unchanged.
  - Miss, taken: allocate the entry, overwriting any alias. Set valid=1, new tag, target ← `jump_addr_ex`, `ctr` ← 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change; no allocation.
- `btb_flush`: clears every `valid` bit. Flush wins over an update in the same cycle. Targets and counters need not be cleared.
- Reset: all `valid`=0, all `ctr` = 2^(CTR_W-1)−1 (weakly not-taken), targets 0. All outputs are therefore 0.
- With `CTR_W`=1: allocation sets `ctr`=1, and the counter simply follows the last outcome.

## Timing
- Lookup latency is 0 cycles (combinational). Update latency is 1 cycle: an update at edge N is visible to lookups after edge N.
- Update and lookup on the same index in the same cycle: the lookup returns pre-update contents.
- Reset mid-operation: state is cleared immediately and asynchronously. The first update is accepted on the first edge after `rst` deasserts.
- No handshake. Every `update_btb_ex` pulse is consumed in its cycle.

## Configuration
- `BTB_STATS_EN` defined: three saturating `STAT_W` counters are built. All are reset to 0 by `rst` or `stat_clr`; `stat_clr` has priority over incrementing.
  - `stat_lookups` +1 per cycle with `lookup_en`=1.
  - `stat_hits` +1 per cycle with `lookup_en` && `btb_hit`.
  - `stat_mispredicts` +1 per cycle with `modify_pc_ex`=1.
  - Each counter holds at all-ones when full.
- `BTB_STATS_EN` undefined: no counters are built. The `stat_*` outputs are tied to 0 and `stat_clr` is ignored.

## Test plan
- Reset check (defaults, `ENTRIES`=16, `TAG_W`=8): `pc_if`=0x100 → `btb_hit`=0, `predicted_taken`=0, `predicted_target`=0.
- Allocation: update `pc_ex`=0x100, taken, target 0x80. Next cycle `pc_if`=0x100 → hit=1, taken=1, target=0x80. A not-taken update to `pc_ex`=0x200 allocates nothing.
- Counter saturation:
  - Three not-taken updates on 0x100 → ctr 2→1→0→0; prediction flips to not-taken after the first.
  - Four taken updates → ctr 1,2,3,3; prediction returns to taken at ctr=2.
- Alias replacement: 0x140 maps to the same index as 0x100 with a different tag. Taken update on 0x140, target 0x200 → lookup 0x140 hits with target 0x200; lookup 0x100 misses.
- Same-cycle collision and flush:
  - Update 0x100 with target 0x300 while `pc_if`=0x100 → that cycle returns 0x80, the next cycle 0x300.
  - `btb_flush` together with an update → next cycle every lookup misses.
- `BTB_STATS_EN` build:
  - 10 cycles with `lookup_en` on an allocated PC → `stat_lookups`=10, `stat_hits`=10.
  - Two `modify_pc_ex` pulses → `stat_mispredicts`=2.
  - `stat_clr` → all 0 next cycle.
  - With `STAT_W`=4, 20 lookups → `stat_lookups`=15.

Source files
------------

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with per-entry saturating
// direction counters for the IF stage of the RV32I pipeline.
// Lookup is combinational from the fetch PC; training comes from EX one cycle later.
// Optional macro BTB_STATS_EN builds lookup/hit/mispredict statistics counters.
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_en,
    input  logic [31:0]       pc_if,
    output logic              predicted_taken,
    output logic [31:0]       predicted_target,
    output logic              btb_hit,
    input  logic              update_btb_ex,
    input  logic [31:0]       pc_ex,
    input  logic [31:0]       jump_addr_ex,
    input  logic              ex_branch_taken,
    input  logic              modify_pc_ex,
    input  logic              btb_flush,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Counter encodings: MSB set means "predict taken".
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN     = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WEAK_NOT_TAKEN = CTR_W'(2 ** (CTR_W - 1) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX            = '1;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;

    logic             ex_hit;
    logic [CTR_W-1:0] ex_ctr;
    logic [CTR_W-1:0] ctr_inc;
    logic [CTR_W-1:0] ctr_dec;

    // Low two PC bits and bits above the tag never participate in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if, pc_ex};

    assign if_idx = pc_if[IDX_W+1:2];
    assign if_tag = pc_if[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = pc_ex[IDX_W+1:2];
    assign ex_tag = pc_ex[IDX_W+TAG_W+1:IDX_W+2];

    // Fetch-side lookup; reads pre-update contents when EX writes the same entry.
    always_comb begin
        btb_hit          = valid[if_idx] && (tag_mem[if_idx] == if_tag);
        predicted_taken  = btb_hit && ctr_mem[if_idx][CTR_W-1];
        predicted_target = btb_hit ? target_mem[if_idx] : 32'h0;
    end

    // EX-side hit detection and saturating counter neighbours of the resolving entry.
    always_comb begin
        ex_hit  = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
        ex_ctr  = ctr_mem[ex_idx];
        ctr_inc = (ex_ctr == CTR_MAX) ? ex_ctr : ex_ctr + CTR_W'(1);
        ctr_dec = (ex_ctr == '0) ? ex_ctr : ex_ctr - CTR_W'(1);
    end

    // Entry storage: flush beats training; a not-taken miss never allocates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= CTR_WEAK_NOT_TAKEN;
            end
        end else if (btb_flush) begin
            valid <= '0;
        end else if (update_btb_ex) begin
            if (ex_hit) begin
                if (ex_branch_taken) begin
                    ctr_mem[ex_idx]    <= ctr_inc;
                    target_mem[ex_idx] <= jump_addr_ex;
                end else begin
                    ctr_mem[ex_idx]    <= ctr_dec;
                end
            end else if (ex_branch_taken) begin
                valid[ex_idx]      <= 1'b1;
                tag_mem[ex_idx]    <= ex_tag;
                target_mem[ex_idx] <= jump_addr_ex;
                ctr_mem[ex_idx]    <= CTR_WEAK_TAKEN;
            end
        end
    end

`ifdef BTB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] lookups_q;
    logic [STAT_W-1:0] hits_q;
    logic [STAT_W-1:0] mispredicts_q;

    // Saturating event counters; clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else if (stat_clr) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            if (lookup_en && (lookups_q != STAT_MAX)) begin
                lookups_q <= lookups_q + STAT_W'(1);
            end
            if (lookup_en && btb_hit && (hits_q != STAT_MAX)) begin
                hits_q <= hits_q + STAT_W'(1);
            end
            if (modify_pc_ex && (mispredicts_q != STAT_MAX)) begin
                mispredicts_q <= mispredicts_q + STAT_W'(1);
            end
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = mispredicts_q;
`else
    // Without statistics the event inputs have no consumer.
    logic unused_stat_inputs;
    assign unused_stat_inputs = ^{lookup_en, modify_pc_ex, stat_clr};

    assign stat_lookups     = '0;
    assign stat_hits        = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed vector table, async-reset sequence, randomized
// run against an array-based reference model, and statistics checks.
module tb_btb_predictor;

    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int STAT_W  = 32;
    localparam int IDX_W   = 4;
    localparam int N_VEC   = 23;
    localparam int N_RAND  = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic              lookup_en;
    logic [31:0]       pc_if;
    logic              predicted_taken;
    logic [31:0]       predicted_target;
    logic              btb_hit;
    logic              update_btb_ex;
    logic [31:0]       pc_ex;
    logic [31:0]       jump_addr_ex;
    logic              ex_branch_taken;
    logic              modify_pc_ex;
    logic              btb_flush;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_hits;
    logic [STAT_W-1:0] stat_mispredicts;

    int n_cmp  = 0;
    int n_fail = 0;

    btb_predictor #(
        .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .lookup_en(lookup_en), .pc_if(pc_if),
        .predicted_taken(predicted_taken), .predicted_target(predicted_target),
        .btb_hit(btb_hit), .update_btb_ex(update_btb_ex), .pc_ex(pc_ex),
        .jump_addr_ex(jump_addr_ex), .ex_branch_taken(ex_branch_taken),
        .modify_pc_ex(modify_pc_ex), .btb_flush(btb_flush), .stat_clr(stat_clr),
        .stat_lookups(stat_lookups), .stat_hits(stat_hits),
        .stat_mispredicts(stat_mispredicts)
    );

`ifdef BTB_STATS_EN
    logic        s_taken;
    logic [31:0] s_target;
    logic        s_hit;
    logic [3:0]  s_lookups;
    logic [3:0]  s_hits;
    logic [3:0]  s_mispredicts;

    btb_predictor #(
        .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .STAT_W(4)
    ) dut_small (
        .clk(clk), .rst(rst), .lookup_en(lookup_en), .pc_if(pc_if),
        .predicted_taken(s_taken), .predicted_target(s_target),
        .btb_hit(s_hit), .update_btb_ex(update_btb_ex), .pc_ex(pc_ex),
        .jump_addr_ex(jump_addr_ex), .ex_branch_taken(ex_branch_taken),
        .modify_pc_ex(modify_pc_ex), .btb_flush(btb_flush), .stat_clr(stat_clr),
        .stat_lookups(s_lookups), .stat_hits(s_hits),
        .stat_mispredicts(s_mispredicts)
    );
`endif

    always #5 clk = ~clk;

    // Directed vector: inputs for one cycle plus the lookup expected during that cycle.
    typedef struct {
        logic        upd;
        logic [31:0] pcx;
        logic [31:0] tgt;
        logic        tk;
        logic        fl;
        logic [31:0] pcf;
        logic        hit;
        logic        ptk;
        logic [31:0] ptgt;
    } vec_t;

    vec_t vecs [N_VEC];

    // Reference model: one record per direct-mapped slot, counter kept as a plain integer.
    logic        m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (IDX_W + 2)) % (1 << TAG_W);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 32'h0;
            m_ctr[i]    = (1 << (CTR_W - 1)) - 1;
        end
    endtask

    task automatic model_step(input logic upd, input logic [31:0] pcx,
                              input logic [31:0] tgt, input logic tk, input logic fl);
        int unsigned i;
        int unsigned t;
        i = idx_of(pcx);
        t = tag_of(pcx);
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (upd) begin
            if (m_valid[i] && m_tag[i] == t) begin
                if (tk) begin
                    if (m_ctr[i] < (1 << CTR_W) - 1) m_ctr[i] = m_ctr[i] + 1;
                    m_target[i] = tgt;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i] = m_ctr[i] - 1;
                end
            end else if (tk) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = t;
                m_target[i] = tgt;
                m_ctr[i]    = 1 << (CTR_W - 1);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic upd, input logic [31:0] pcx,
                                 input logic [31:0] tgt, input logic tk,
                                 input logic fl, input logic [31:0] pcf);
        update_btb_ex   = upd;
        pc_ex           = pcx;
        jump_addr_ex    = tgt;
        ex_branch_taken = tk;
        btb_flush       = fl;
        pc_if           = pcf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lookup(input string tag_name, input logic e_hit,
                                input logic e_tk, input logic [31:0] e_tgt);
        checkOutput({tag_name, ".hit"}, {31'h0, btb_hit}, {31'h0, e_hit});
        checkOutput({tag_name, ".taken"}, {31'h0, predicted_taken}, {31'h0, e_tk});
        checkOutput({tag_name, ".target"}, predicted_target, e_tgt);
    endtask

    initial begin
        logic [31:0] r_pcx;
        logic [31:0] r_pcf;
        logic [31:0] r_tgt;
        logic        r_upd;
        logic        r_tk;
        logic        r_fl;
        int unsigned li;
        logic        e_hit;

        vecs[0]  = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h000};
        vecs[1]  = '{1'b1, 32'h100, 32'h080, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h000};
        vecs[2]  = '{1'b1, 32'h200, 32'h0F0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[3]  = '{1'b1, 32'h100, 32'h000, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 32'h000};
        vecs[4]  = '{1'b1, 32'h100, 32'h000, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[5]  = '{1'b1, 32'h100, 32'h000, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[6]  = '{1'b1, 32'h100, 32'h080, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[7]  = '{1'b1, 32'h100, 32'h080, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[8]  = '{1'b1, 32'h100, 32'h080, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[9]  = '{1'b1, 32'h100, 32'h080, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[10] = '{1'b1, 32'h100, 32'h000, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[11] = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[12] = '{1'b1, 32'h140, 32'h200, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[13] = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h140, 1'b1, 1'b1, 32'h200};
        vecs[14] = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h000};
        vecs[15] = '{1'b1, 32'h100, 32'h080, 1'b1, 1'b0, 32'h140, 1'b1, 1'b1, 32'h200};
        vecs[16] = '{1'b1, 32'h100, 32'h300, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[17] = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h300};
        vecs[18] = '{1'b1, 32'h104, 32'h044, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h300};
        vecs[19] = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h000};
        vecs[20] = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 32'h000};
        vecs[21] = '{1'b1, 32'h100, 32'h000, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h000};
        vecs[22] = '{1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h000};

        rst          = 1'b1;
        lookup_en    = 1'b0;
        modify_pc_ex = 1'b0;
        stat_clr     = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
        #12;
        rst = 1'b0;
        tick();

        checkOutput("reset.stat_lookups", stat_lookups, 32'h0);
        checkOutput("reset.stat_hits", stat_hits, 32'h0);
        checkOutput("reset.stat_mispredicts", stat_mispredicts, 32'h0);

        for (int v = 0; v < N_VEC; v++) begin
            applyStimulus(vecs[v].upd, vecs[v].pcx, vecs[v].tgt, vecs[v].tk,
                          vecs[v].fl, vecs[v].pcf);
            #1;
            check_lookup($sformatf("vec%0d", v), vecs[v].hit, vecs[v].ptk, vecs[v].ptgt);
            tick();
        end

        // Asynchronous reset in the middle of a cycle clears state without a clock edge.
        applyStimulus(1'b1, 32'h100, 32'h0AA, 1'b1, 1'b0, 32'h100);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
        #1;
        check_lookup("pre_async_rst", 1'b1, 1'b1, 32'h0AA);
        #1;
        rst = 1'b1;
        #1;
        check_lookup("async_rst", 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h100, 32'h055, 1'b1, 1'b0, 32'h100);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
        #1;
        check_lookup("post_rst_update", 1'b1, 1'b1, 32'h055);

        // Randomized traffic on a small PC pool to exercise hits, aliases and saturation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < N_RAND; n++) begin
            r_pcx = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 3)) << 6)
                  | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            r_pcf = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 3)) << 6)
                  | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            r_tgt = $urandom;
            r_upd = ($urandom_range(0, 9) < 6);
            r_tk  = $urandom_range(0, 1) == 1;
            r_fl  = ($urandom_range(0, 49) == 0);
            applyStimulus(r_upd, r_pcx, r_tgt, r_tk, r_fl, r_pcf);
            #1;
            li    = idx_of(r_pcf);
            e_hit = m_valid[li] && (m_tag[li] == tag_of(r_pcf));
            check_lookup($sformatf("rand%0d", n), e_hit,
                         e_hit && (m_ctr[li] >= (1 << (CTR_W - 1))),
                         e_hit ? m_target[li] : 32'h0);
            model_step(r_upd, r_pcx, r_tgt, r_tk, r_fl);
            tick();
        end

        // Statistics: allocate a PC, clear, then count lookups, hits and redirects.
        applyStimulus(1'b1, 32'h100, 32'h080, 1'b1, 1'b0, 32'h100);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
        stat_clr = 1'b1;
        tick();
        stat_clr  = 1'b0;
        lookup_en = 1'b1;
        repeat (10) tick();
        lookup_en = 1'b0;
        modify_pc_ex = 1'b1;
        tick();
        modify_pc_ex = 1'b0;
        tick();
        modify_pc_ex = 1'b1;
        tick();
        modify_pc_ex = 1'b0;
`ifdef BTB_STATS_EN
        checkOutput("stat.lookups10", stat_lookups, 32'd10);
        checkOutput("stat.hits10", stat_hits, 32'd10);
        checkOutput("stat.mispredicts2", stat_mispredicts, 32'd2);
`else
        checkOutput("nostat.lookups", stat_lookups, 32'h0);
        checkOutput("nostat.hits", stat_hits, 32'h0);
        checkOutput("nostat.mispredicts", stat_mispredicts, 32'h0);
`endif
        stat_clr     = 1'b1;
        lookup_en    = 1'b1;
        modify_pc_ex = 1'b1;
        tick();
        stat_clr     = 1'b0;
        lookup_en    = 1'b0;
        modify_pc_ex = 1'b0;
        checkOutput("clr.lookups", stat_lookups, 32'h0);
        checkOutput("clr.hits", stat_hits, 32'h0);
        checkOutput("clr.mispredicts", stat_mispredicts, 32'h0);
        lookup_en = 1'b1;
        repeat (20) tick();
        lookup_en = 1'b0;
`ifdef BTB_STATS_EN
        checkOutput("stat.lookups20", stat_lookups, 32'd20);
        checkOutput("stat.hits20", stat_hits, 32'd20);
        checkOutput("stat4.lookups_sat", {28'h0, s_lookups}, 32'd15);
        checkOutput("stat4.hits_sat", {28'h0, s_hits}, 32'd15);
`else
        checkOutput("nostat.lookups20", stat_lookups, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
